// File: rtl/wsg_mixer_dac.sv
// rtl/wsg_mixer_dac.sv - WSG 8-slot channel mixer with 48 kHz PCM frame output and first-order delta-sigma DAC
module wsg_mixer_dac #(
  parameter logic [3:0] SAMPLE_PHASE = 4'hC
) (
  input  logic        pxclk,
  input  logic        RESET,
  input  logic [7:0]  c99_in,
  input  logic [7:0]  ch_mask,
  input  logic        mute,
  output logic [15:0] pcm_out,
  output logic        pcm_valid,
  output logic        dac_out
);

  logic [6:0]         phase;
  logic [2:0]         slot;
  logic               capture;
  logic               frame_end;
  logic signed [4:0]  vol_s;
  logic signed [4:0]  wave_s;
  logic signed [9:0]  prod;
  logic signed [10:0] term;
  logic signed [10:0] acc;
  logic [15:0]        ds_acc;
  logic [15:0]        u;
  logic [16:0]        sum17;

  assign slot      = phase[6:4];
  assign capture   = (phase[3:0] == SAMPLE_PHASE);
  assign frame_end = (phase == 7'h7F);

  // Wave sample is re-centred to -8..+7 before scaling by the unsigned volume
  assign vol_s  = $signed({1'b0, c99_in[7:4]});
  assign wave_s = $signed({1'b0, c99_in[3:0]}) - 5'sd8;
  assign prod   = vol_s * wave_s;
  assign term   = ch_mask[slot] ? $signed({prod[9], prod}) : 11'sd0;

  // Offset-binary view of the PCM word drives the modulator
  assign u     = {~pcm_out[15], pcm_out[14:0]};
  assign sum17 = {1'b0, ds_acc} + {1'b0, u};

  always_ff @(posedge pxclk or posedge RESET) begin
    if (RESET) begin
      phase     <= 7'd0;
      acc       <= 11'sd0;
      pcm_out   <= 16'd0;
      pcm_valid <= 1'b0;
      ds_acc    <= 16'd0;
      dac_out   <= 1'b0;
    end else begin
      phase <= phase + 7'd1;

      // Slot 0 restarts the sum so no previous frame leaks through
      if (capture) begin
        if (slot == 3'd0) acc <= term;
        else              acc <= acc + term;
      end

      pcm_valid <= frame_end;
      if (frame_end) pcm_out <= mute ? 16'd0 : {acc, 5'b00000};

      ds_acc  <= sum17[15:0];
      dac_out <= sum17[16];
    end
  end

endmodule

// File: tb/tb_wsg_mixer_dac.sv
// tb/tb_wsg_mixer_dac.sv - randomized self-checking bench for wsg_mixer_dac against an integer frame model
module tb_wsg_mixer_dac;

  logic        pxclk = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  c99_in = 8'h00;
  logic [7:0]  ch_mask = 8'h00;
  logic        mute = 1'b0;
  logic [15:0] pcm_out;
  logic        pcm_valid;
  logic        dac_out;

  int checks = 0;
  int errors = 0;
  int mode = 0;

  wsg_mixer_dac #(.SAMPLE_PHASE(4'hC)) dut (
    .pxclk(pxclk), .RESET(RESET), .c99_in(c99_in), .ch_mask(ch_mask),
    .mute(mute), .pcm_out(pcm_out), .pcm_valid(pcm_valid), .dac_out(dac_out)
  );

  always #5 pxclk = ~pxclk;

  // Reference: frame position, running slot sum, PCM word and modulator residue as plain integers
  int m_phase = 0, m_acc = 0, m_pcm = 0, m_ds = 0;
  int m_valid = 0, m_dac = 0;
  int mu, ms, mslot, mterm;

  always @(posedge pxclk or posedge RESET) begin
    if (RESET) begin
      m_phase = 0; m_acc = 0; m_pcm = 0; m_ds = 0; m_valid = 0; m_dac = 0;
    end else begin
      mu = m_pcm + 32768;
      ms = m_ds + mu;
      m_dac = (ms >= 65536) ? 1 : 0;
      m_ds = ms % 65536;
      if (m_phase % 16 == 12) begin
        mslot = m_phase / 16;
        mterm = ch_mask[mslot] ? int'(c99_in[7:4]) * (int'(c99_in[3:0]) - 8) : 0;
        m_acc = (mslot == 0) ? mterm : m_acc + mterm;
      end
      m_valid = (m_phase == 127) ? 1 : 0;
      if (m_valid == 1) m_pcm = mute ? 0 : m_acc * 32;
      m_phase = (m_phase + 1) % 128;
    end
  end

  int printed = 0;
  always @(negedge pxclk) begin
    checks += 3;
    if (int'($signed(pcm_out)) != m_pcm) begin
      errors++;
      if (printed < 30) $display("FAIL pcm_out got %0d want %0d at %0t", $signed(pcm_out), m_pcm, $time);
      printed++;
    end
    if (int'(pcm_valid) != m_valid) begin
      errors++;
      if (printed < 30) $display("FAIL pcm_valid got %0d want %0d at %0t", pcm_valid, m_valid, $time);
      printed++;
    end
    if (int'(dac_out) != m_dac) begin
      errors++;
      if (printed < 30) $display("FAIL dac_out got %0d want %0d at %0t", dac_out, m_dac, $time);
      printed++;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  // Called just after each rising edge; m_phase is then the phase of the next capture edge
  task automatic drive();
    case (mode)
      1: c99_in = (m_phase / 16 == 0) ? 8'hF7 : (m_phase / 16 == 3) ? 8'h2F : 8'h08;
      2: begin
        c99_in = 8'($urandom);
        if (m_phase % 16 == 0) ch_mask = 8'($urandom);
        mute = ($urandom_range(0, 3) == 0);
      end
      3: mute = (m_phase == 127);
      4: mute = (m_phase == 64);
      default: ;
    endcase
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pxclk); #2;
      drive();
    end
  endtask

  task automatic wait_valid(output int cyc);
    bit found;
    found = 0;
    cyc = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge pxclk); #1;
      cyc++;
      if (pcm_valid) found = 1;
      #1;
      drive();
    end
    if (!found) begin
      errors++;
      checks++;
      $display("FAIL wait_valid timeout after %0d cycles", cyc);
      cyc = -1;
    end
  endtask

  int cyc, ones;

  initial begin
    step(3);
    RESET = 1'b0;

    // Silent input: alternating bitstream from the first edge, valid every 128 cycles
    for (int k = 0; k < 8; k++) begin
      @(posedge pxclk); #1;
      chk("dac_idle_pattern", int'(dac_out), k % 2);
      #1;
    end
    wait_valid(cyc);
    chk("first_valid_latency", cyc + 8, 128);
    chk("idle_pcm", int'($signed(pcm_out)), 0);
    wait_valid(cyc);
    chk("valid_period", cyc, 128);

    c99_in = 8'hFF; ch_mask = 8'h01;
    wait_valid(cyc);
    chk("single_channel_max", int'($signed(pcm_out)), 3360);

    c99_in = 8'hF0; ch_mask = 8'hFF;
    wait_valid(cyc);
    chk("all_channels_min", int'($signed(pcm_out)), -30720);
    ones = 0;
    for (int i = 0; i < 8192; i++) begin
      @(negedge pxclk);
      ones += int'(dac_out);
    end
    chk("dac_density_min", ones, 256);

    mode = 1;
    wait_valid(cyc);
    wait_valid(cyc);
    chk("per_slot_mix", int'($signed(pcm_out)), -32);

    mode = 3; c99_in = 8'hFF; ch_mask = 8'hFF;
    wait_valid(cyc);
    wait_valid(cyc);
    chk("mute_at_frame_edge", int'($signed(pcm_out)), 0);
    chk("mute_valid_period", cyc, 128);
    mode = 4;
    wait_valid(cyc);
    chk("mute_mid_frame_ignored", int'($signed(pcm_out)), 26880);

    mode = 0; mute = 1'b0;
    for (int i = 0; i < 200 && m_phase != 69; i++) step(1);
    chk("reach_phase_45", m_phase, 69);
    RESET = 1'b1;
    step(3);
    chk("reset_pcm", int'(pcm_out), 0);
    chk("reset_dac", int'(dac_out), 0);
    RESET = 1'b0;
    wait_valid(cyc);
    chk("post_reset_latency", cyc, 128);
    chk("post_reset_pcm", int'($signed(pcm_out)), 26880);

    mode = 2;
    step(128 * 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wsg_mixer_dac.md
WSG_MIXER_DAC -- requirements
Module: wsg_mixer_dac

Interface
REQ-001 SHALL have parameter SAMPLE_PHASE, default 4'hC: sub-slot phase (phase[3:0]) at which c99_in is captured.
REQ-002 SHALL have input pxclk, 1 bit: 6.144 MHz system clock; all state rising-edge triggered.
REQ-003 SHALL have input RESET, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have input c99_in, 8 bits: WSG time-multiplexed output; [7:4] = volume (0..15), [3:0] = wave sample (0..15).
REQ-005 SHALL have input ch_mask, 8 bits: per-channel enable; bit n gates slot n.
REQ-006 SHALL have input mute, 1 bit: forces the frame result to zero.
REQ-007 SHALL have output pcm_out, 16 bits, signed: mixed frame sample.
REQ-008 SHALL have output pcm_valid, 1 bit: one-cycle strobe marking a new pcm_out value.
REQ-009 SHALL have output dac_out, 1 bit: first-order delta-sigma bitstream of pcm_out.

Function
REQ-010 SHALL keep a 7-bit phase counter, reset 0, +1 per pxclk, wrapping 7'h7F -> 7'h00; slot = phase[6:4], 16 cycles per slot, 128 cycles per frame (48 kHz).
REQ-011 Counter SHALL be reset-aligned with the upstream WSG phase counter, so the WSG slot n data (updated at WSG phase n8h) is stable at phase {n, SAMPLE_PHASE}.
REQ-012 At phase[3:0] == SAMPLE_PHASE, SHALL compute term = ch_mask[slot] ? vol * (wave - 8) : 0: wave offset to signed -8..+7, product signed 8-bit, range -120..+105.
REQ-013 ch_mask SHALL be sampled at the same edge as c99_in for that slot.
REQ-014 At the slot 0 capture edge, accumulator SHALL load term (no previous-frame carry-over); in slots 1..7 it SHALL add term.
REQ-015 Accumulator SHALL be 11-bit signed (range -960..+840); no overflow or saturation is possible or required.
REQ-016 On the edge where phase == 7'h7F, pcm_out SHALL load mute ? 0 : accumulator sign-extended and shifted left 5 (range -30720..+26880).
REQ-017 mute SHALL be sampled only at the phase 7'h7F edge.
REQ-018 pcm_valid SHALL be registered high for exactly the one cycle following the phase 7'h7F edge (co-incident with the new pcm_out) and low otherwise; period exactly 128 cycles.
REQ-019 pcm_out SHALL hold its value between frame edges.
REQ-020 Delta-sigma path, every pxclk: u = pcm_out with bit 15 inverted (offset binary); sum17 = ds_acc(16 bit) + u; ds_acc <= sum17[15:0]; dac_out <= sum17[16].
REQ-021 dac_out ones density SHALL equal u/65536 over any window of 65536 cycles with constant pcm_out.
REQ-022 The delta-sigma path SHALL use the current registered pcm_out with no extra pipeline delay; a pcm_out change affects dac_out at the next edge.

Reset
REQ-023 While RESET is high: phase, accumulator, pcm_out, ds_acc = 0; pcm_valid = 0; dac_out = 0.
REQ-024 Reset asserted mid-frame SHALL discard the partial accumulation; after release the phase restarts at 0 and the first pcm_valid occurs in the 128th cycle after release.

Verification
REQ-025 Reset release, c99_in = 8'h00, mask = 0: pcm_out stays 0; pcm_valid every 128 cycles; dac_out = 0,1,0,1,... from the first edge.
REQ-026 c99_in = 8'hFF constant, ch_mask = 8'h01: pcm_out = 3360 (16'h0D20) at first valid.
REQ-027 c99_in = 8'hF0 constant, ch_mask = 8'hFF: pcm_out = -30720 (16'h8800); dac_out ones density = 2048/65536.
REQ-028 Per-slot c99_in: slot 0 = 8'hF7, slot 3 = 8'h2F, others = 8'h08, ch_mask = 8'hFF: pcm_out = (15*(-1) + 2*7) * 32 = -32 (16'hFFE0).
REQ-029 Frame with nonzero sum and mute high at phase 7'h7F: pcm_out = 0 and pcm_valid still pulses; mute high only at phase 7'h40: result unaffected.
REQ-030 RESET pulse at phase 7'h45 during a nonzero frame: outputs 0 during reset; first post-release pcm_valid after 128 cycles, carrying only post-release slots.
